// File: rtl/led_pkg.sv
// Shared definitions for the breathing-LED path: the FSM phase encoding that
// status/debug logic decodes from the `phase` output.
package led_pkg;

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HIGH = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LOW  = 2'd3
    } phase_t;

endpackage : led_pkg

// File: rtl/step_tick.sv
// Enable-gated prescaler: one-cycle tick every CYCLES enabled clocks, held at
// zero while disabled so a re-enable always waits a full CYCLES period.
module step_tick #(
    parameter int CYCLES = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == CNT_LAST);
    assign tick    = en & at_last;

    always_comb begin
        cnt_d = '0;
        if (en && !at_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : step_tick

// File: rtl/led_breather.sv
// Breathing LED: triangle duty pattern (ramp up, hold, ramp down, hold) stepped
// by a slow tick, rendered through a period-synchronous PWM and output register.
module led_breather
    import led_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 392_157,
    parameter int HOLD_STEPS  = 64
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                en,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          phase
);

    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);

    if (CLK_HZ < 1 || STEP_CYCLES < 2 || HOLD_STEPS < 1 || PWM_BITS < 1) begin : g_param_check
        $error("led_breather: illegal parameter combination");
    end

    logic tick;

    step_tick #(
        .CYCLES (STEP_CYCLES)
    ) u_step_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .tick   (tick)
    );

    phase_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q,  duty_d;
    logic [HW-1:0]       hold_q,  hold_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] lat_q;
    logic                led_q;

    // Duty saturates at the extremes; the hold states count ticks before turning.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        if (tick) begin
            case (state_q)
                RAMP_UP: begin
                    if (duty_q != DUTY_MAX) begin
                        duty_d = duty_q + 1'b1;
                    end
                    if (duty_q >= DUTY_MAX - 1'b1) begin
                        state_d = HOLD_HIGH;
                        hold_d  = '0;
                    end
                end
                HOLD_HIGH: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_DOWN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (duty_q != '0) begin
                        duty_d = duty_q - 1'b1;
                    end
                    if (duty_q <= {{(PWM_BITS-1){1'b0}}, 1'b1}) begin
                        state_d = HOLD_LOW;
                        hold_d  = '0;
                    end
                end
                HOLD_LOW: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_UP;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RAMP_UP;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= RAMP_UP;
            duty_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
        end
    end

    // Duty is sampled only at the period boundary so a PWM period never glitches.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
            lat_q <= '0;
            led_q <= 1'b0;
        end else begin
            pwm_q <= pwm_q + 1'b1;
            if (pwm_q == DUTY_MAX) begin
                lat_q <= duty_q;
            end
            led_q <= en & (pwm_q < lat_q);
        end
    end

    assign led   = led_q;
    assign duty  = duty_q;
    assign phase = state_q;

endmodule : led_breather

// File: tb/tb_led_breather.sv
// Bench for led_breather: tick-count based pattern model plus PWM/latch model,
// random enable stimulus, and directed enable-drop and async-reset scenarios.
module tb_led_breather;

    localparam int PB     = 3;
    localparam int SC     = 4;
    localparam int HS     = 2;
    localparam int M      = (1 << PB) - 1;
    localparam int PERIOD = 2 * M + 2 * HS;

    logic          clk_in = 1'b0;
    logic          rst    = 1'b0;
    logic          en     = 1'b0;
    logic          led;
    logic [PB-1:0] duty;
    logic [1:0]    phase;

    int checks = 0;
    int errors = 0;

    int m_presc;
    int m_ticks;
    int m_pwm;
    int m_lat;
    int m_led;
    int cyc;

    led_breather #(
        .CLK_HZ      (100_000_000),
        .PWM_BITS    (PB),
        .STEP_CYCLES (SC),
        .HOLD_STEPS  (HS)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .led    (led),
        .duty   (duty),
        .phase  (phase)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pattern position after n ticks, straight from the triangle definition.
    function automatic int f_duty(input int n);
        int t;
        t = n % PERIOD;
        if (t < M)          return t;
        if (t < M + HS)     return M;
        if (t < 2 * M + HS) return M - (t - (M + HS));
        return 0;
    endfunction

    function automatic int f_phase(input int n);
        int t;
        t = n % PERIOD;
        if (t < M)          return 0;
        if (t < M + HS)     return 1;
        if (t < 2 * M + HS) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_presc = 0;
        m_ticks = 0;
        m_pwm   = 0;
        m_lat   = 0;
        m_led   = 0;
        cyc     = 0;
    endtask

    // Advance one clock with the currently driven en, then compare all outputs.
    task automatic step_cycle();
        bit e;
        bit tk;
        int dprev;
        e     = en;
        tk    = e && (m_presc == SC - 1);
        dprev = f_duty(m_ticks);
        @(posedge clk_in);
        m_led = (e && (m_pwm < m_lat)) ? 1 : 0;
        if (m_pwm == M) m_lat = dprev;
        m_pwm   = (m_pwm + 1) % (M + 1);
        m_presc = e ? (tk ? 0 : m_presc + 1) : 0;
        if (tk) begin
            m_ticks++;
            $display("tick %0d @cycle %0d: expect duty=%0d phase=%0d", m_ticks, cyc + 1,
                     f_duty(m_ticks), f_phase(m_ticks));
        end
        cyc++;
        #1;
        check_eq("duty",  32'(duty),  32'(f_duty(m_ticks)));
        check_eq("phase", 32'(phase), 32'(f_phase(m_ticks)));
        check_eq("led",   32'(led),   32'(m_led));
    endtask

    initial begin
        int i;
        model_reset();
        #1 rst = 1'b1;
        #2;
        check_eq("rst_duty",  32'(duty),  32'd0);
        check_eq("rst_phase", 32'(phase), 32'd0);
        check_eq("rst_led",   32'(led),   32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        en  = 1'b1;
        model_reset();

        // Free run: one full ramp and the full pattern period.
        repeat (80) begin
            step_cycle();
            if (cyc == 28) begin
                check_eq("c28_duty",  32'(duty),  32'd7);
                check_eq("c28_phase", 32'(phase), 32'd1);
            end
            if (cyc == 72) begin
                check_eq("c72_duty",  32'(duty),  32'd0);
                check_eq("c72_phase", 32'(phase), 32'd0);
            end
        end

        // Random enable runs.
        repeat (1500) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            step_cycle();
        end

        // Drop en at duty 4 during RAMP_UP.
        en = 1'b1;
        i  = 0;
        while (!(f_phase(m_ticks) == 0 && f_duty(m_ticks) == 4) && i < 400) begin
            step_cycle();
            i++;
        end
        check_eq("find_duty4", 32'(f_duty(m_ticks)), 32'd4);
        en = 1'b0;
        repeat (10) step_cycle();
        check_eq("frozen_duty", 32'(duty), 32'd4);
        check_eq("frozen_led",  32'(led),  32'd0);
        en = 1'b1;
        repeat (3) step_cycle();
        check_eq("resume_wait", 32'(duty), 32'd4);
        step_cycle();
        check_eq("resume_step", 32'(duty), 32'd5);

        // Async reset between edges while holding high.
        i = 0;
        while (f_phase(m_ticks) != 1 && i < 400) begin
            step_cycle();
            i++;
        end
        check_eq("find_hold", 32'(phase), 32'd1);
        repeat (2) step_cycle();
        #2 rst = 1'b1;
        #1;
        check_eq("arst_led",   32'(led),   32'd0);
        check_eq("arst_duty",  32'(duty),  32'd0);
        check_eq("arst_phase", 32'(phase), 32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        repeat (100) step_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_led_breather
